instr_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the word-addressed instruction ROM: holds the program counter, drives the ROM byte address, captures each returned word with its PC into a 2-entry buffer, and presents instructions to the decode stage over a valid/ready handshake. Sits between the instruction ROM and the decoder. Accepts branch/jump redirects, halt requests and end-of-program detection.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, buffer entry
// layout and the word-alignment helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HALT,
    END,
    ERR
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer. The pointers carry one extra wrap bit,
// so full and empty can be told apart without a separate occupancy counter.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  fetch_entry_t i_wdata,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  fetch_entry_t r_mem [DEPTH];
  fetch_entry_t r_last;

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // r_last keeps the most recent head so the outputs hold once the buffer drains
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (!o_empty) begin
        r_last <= r_mem[w_rd_idx];
      end
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) begin
          r_mem[w_wr_idx] <= i_wdata;
          r_wr_ptr        <= r_wr_ptr + PTR_ONE;
        end
        if (w_do_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

  assign o_head = o_empty ? r_last : r_mem[w_rd_idx];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, walks the combinational ROM and
// feeds {pc, instr} pairs to the decoder through a small valid/ready buffer.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_WORDS  = 62,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        done,
  output logic        misalign_err
);

  localparam logic [31:0] LAST_PC = 32'(ROM_WORDS * INSTR_BYTES - INSTR_BYTES);
  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic         r_done;
  logic         r_misalign;

  logic         w_redirect_ok;
  logic         w_redirect_bad;
  logic         w_past_end;
  logic         w_flush;
  logic         w_push;
  logic         w_pop;
  logic         w_load_reset;
  logic         w_set_done;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  assign w_redirect_ok  = redirect_valid && (r_state != ERR) && is_aligned(redirect_pc[1:0]);
  assign w_redirect_bad = redirect_valid && (r_state != ERR) && !is_aligned(redirect_pc[1:0]);
  assign w_past_end     = (r_pc > LAST_PC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Redirects win over everything; ERR is left only through reset
  always_comb begin
    w_next_state = r_state;
    if (w_redirect_ok) begin
      w_next_state = FETCH;
    end else if (w_redirect_bad) begin
      w_next_state = ERR;
    end else begin
      case (r_state)
        IDLE:    if (run) w_next_state = FETCH;
        FETCH: begin
          if (halt_req) begin
            w_next_state = HALT;
          end else if (w_past_end) begin
            w_next_state = END;
          end
        end
        HALT:    if (run) w_next_state = FETCH;
        default: w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    w_flush      = w_redirect_ok || w_redirect_bad;
    w_pop        = instr_valid && instr_ready && !w_flush;
    w_load_reset = !w_flush && (r_state == IDLE) && run;
    w_push       = 1'b0;
    w_set_done   = 1'b0;
    if (!w_flush && (r_state == FETCH) && !halt_req) begin
      if (w_past_end) begin
        w_set_done = 1'b1;
      end else begin
        w_push = !w_full || w_pop;
      end
    end
  end

  // done can only be set while heading into END, so any aligned redirect clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_redirect_ok) begin
        r_pc <= redirect_pc;
      end else if (w_load_reset) begin
        r_pc <= RESET_PC;
      end else if (w_push) begin
        r_pc <= r_pc + PC_STEP;
      end
      if (w_redirect_ok) begin
        r_done <= 1'b0;
      end else if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_redirect_bad) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = imem_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr    = r_pc;
  assign instr_valid  = !w_empty;
  assign instr_data   = w_head.instr;
  assign instr_pc     = w_head.pc;
  assign done         = r_done;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: streaming, stalls, redirects, misaligned
// redirect, halt/resume and asynchronous reset, against a combinational ROM model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        done;
  logic        misalign_err;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    return 32'h1300_0013 + (addr << 8);
  endfunction

  assign imem_data = romWord(imem_addr);

  instr_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .ROM_WORDS  (62),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .done           (done),
    .misalign_err   (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic runV, input logic haltV, input logic redirV,
                               input logic [31:0] redirPcV, input logic readyV);
    run            = runV;
    halt_req       = haltV;
    redirect_valid = redirV;
    redirect_pc    = redirPcV;
    instr_ready    = readyV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt;

    // Reset values
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    checkOutput("rstAddr", imem_addr, 32'h0);
    checkOutput("rstValid", 32'(instr_valid), 32'h0);
    checkOutput("rstData", instr_data, 32'h0);
    checkOutput("rstPc", instr_pc, 32'h0);
    checkOutput("rstDone", 32'(done), 32'h0);
    checkOutput("rstErr", 32'(misalign_err), 32'h0);
    step();
    reset_n = 1'b1;

    // Streaming with ready held high, then run off the ROM end
    $display("[TB] streaming fetch");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("runValid0", 32'(instr_valid), 32'h0);
    checkOutput("runAddr0", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("streamValid", 32'(instr_valid), 32'h1);
      checkOutput("streamPc", instr_pc, 32'(k * 4));
      checkOutput("streamData", instr_data, romWord(32'(k * 4)));
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    checkOutput("endCycles", 32'(cnt), 32'd59);
    checkOutput("endDone", 32'(done), 32'h1);
    checkOutput("endValid", 32'(instr_valid), 32'h0);
    checkOutput("endAddr", imem_addr, 32'd248);
    checkOutput("endHoldPc", instr_pc, 32'd244);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("endRunAddr", imem_addr, 32'd248);
    checkOutput("endRunValid", 32'(instr_valid), 32'h0);
    checkOutput("endRunDone", 32'(done), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    step();
    checkOutput("endRedirDone", 32'(done), 32'h0);
    checkOutput("endRedirAddr", imem_addr, 32'h20);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("endRedirPc", instr_pc, 32'h20);
    checkOutput("endRedirData", instr_data, romWord(32'h20));

    // Stall with ready low, then drain in order
    $display("[TB] stall and release");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    step();
    checkOutput("stallAddr", imem_addr, 32'h8);
    checkOutput("stallValid", 32'(instr_valid), 32'h1);
    checkOutput("stallPc", instr_pc, 32'h0);
    checkOutput("stallData", instr_data, romWord(32'h0));
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("drainPc4", instr_pc, 32'h4);
    step();
    checkOutput("drainPc8", instr_pc, 32'h8);
    step();
    checkOutput("drainPc12", instr_pc, 32'hC);

    // Aligned redirect with two entries buffered
    $display("[TB] aligned redirect");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    checkOutput("preRedirAddr", imem_addr, 32'h10);
    checkOutput("preRedirPc", instr_pc, 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
    step();
    checkOutput("redirFlushValid", 32'(instr_valid), 32'h0);
    checkOutput("redirAddr", imem_addr, 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("redirValid", 32'(instr_valid), 32'h1);
    checkOutput("redirPc", instr_pc, 32'h8);
    checkOutput("redirData", instr_data, romWord(32'h8));

    // Misaligned redirect locks into ERR
    $display("[TB] misaligned redirect");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h6, 1'b1);
    step();
    checkOutput("errFlag", 32'(misalign_err), 32'h1);
    checkOutput("errValid", 32'(instr_valid), 32'h0);
    checkOutput("errAddr", imem_addr, 32'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    checkOutput("errRunValid", 32'(instr_valid), 32'h0);
    checkOutput("errRunAddr", imem_addr, 32'h10);
    checkOutput("errSticky", 32'(misalign_err), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    step();
    checkOutput("errRedirAddr", imem_addr, 32'h10);
    checkOutput("errRedirValid", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("errRstFlag", 32'(misalign_err), 32'h0);
    checkOutput("errRstAddr", imem_addr, 32'h0);
    step();
    reset_n = 1'b1;

    // Halt at PC 12 with two entries buffered, drain, resume
    $display("[TB] halt and resume");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    checkOutput("preHaltAddr", imem_addr, 32'hC);
    checkOutput("preHaltPc", instr_pc, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("haltPc", instr_pc, 32'h8);
    checkOutput("haltValid", 32'(instr_valid), 32'h1);
    checkOutput("haltAddr", imem_addr, 32'hC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("haltDrained", 32'(instr_valid), 32'h0);
    step();
    checkOutput("haltIdleValid", 32'(instr_valid), 32'h0);
    checkOutput("haltIdleAddr", imem_addr, 32'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("resumeValid0", 32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("resumeValid", 32'(instr_valid), 32'h1);
    checkOutput("resumePc", instr_pc, 32'hC);
    checkOutput("resumeData", instr_data, romWord(32'hC));

    // Asynchronous reset with a full buffer
    $display("[TB] async reset mid-stream");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    checkOutput("fullValid", 32'(instr_valid), 32'h1);
    checkOutput("fullPc", instr_pc, 32'hC);
    checkOutput("fullAddr", imem_addr, 32'h14);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncValid", 32'(instr_valid), 32'h0);
    checkOutput("asyncAddr", imem_addr, 32'h0);
    checkOutput("asyncPc", instr_pc, 32'h0);
    checkOutput("asyncData", instr_data, 32'h0);
    step();
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
